instr_register_exec: RTL and testbench

INSTR_REGISTER_EXEC -- requirements
Module: instr_register_exec

---
 rtl/instr_register_pkg.sv | 33 +++
 rtl/instr_divider.sv | 60 ++++++
 rtl/instr_register_exec.sv | 143 ++++++++++++++
 tb/tb_instr_register_exec.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register / execute block.
// Opcode is 4 bits wide so undefined encodings (8..15) can be presented and rejected.
package instr_register_pkg;

    localparam int DEPTH = 32;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic        [4:0]  address_t;
    typedef logic signed [63:0] result_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  rezultat;
    } instruction_t;

    function automatic result_t sext(input operand_t v);
        return result_t'(v);
    endfunction

endpackage

// File: rtl/instr_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; result ready CYCLES edges after start.
// No backpressure: a start pulse reloads the operands and restarts unconditionally.
module instr_divider #(
    parameter int WIDTH  = 32,
    parameter int CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(CYCLES + 1);

    logic             busy;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    // quotient doubles as the dividend shift register
    assign rem_sh = {remainder, quotient[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dvs};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
            dvs       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (start) begin
            busy      <= 1'b1;
            done      <= 1'b0;
            cnt       <= '0;
            dvs       <= divisor;
            quotient  <= dividend;
            remainder <= '0;
        end else if (busy) begin
            if (!diff[WIDTH]) begin
                remainder <= diff[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b1};
            end else begin
                remainder <= rem_sh[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CW'(CYCLES - 1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_register_exec.sv
// Instruction store with a one-at-a-time execute unit; result valid 2 edges after accept, DIV_CYCLES+2 for divides.
// load_ready is high only when idle; writes presented while busy are dropped, not queued.
module instr_register_exec
    import instr_register_pkg::*;
#(
    parameter int DEPTH      = instr_register_pkg::DEPTH,
    parameter int DIV_CYCLES = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_en,
    output logic         load_ready,
    input  address_t     write_pointer,
    input  opcode_t      opcode,
    input  operand_t     operand_a,
    input  operand_t     operand_b,
    input  address_t     read_pointer,
    output instruction_t instruction_word,
    output logic         entry_valid,
    output logic         div_by_zero
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DIVIDE, S_WRITEBACK} state_t;

    state_t           state;
    instruction_t     mem [DEPTH];
    logic [DEPTH-1:0] valid;
    address_t         cur_ptr;
    logic [CW-1:0]    div_cnt;

    logic         accept;
    logic         is_div_op;
    logic         div_start;
    logic [31:0]  mag_a;
    logic [31:0]  mag_b;
    logic         div_done;
    logic [31:0]  div_quotient;
    logic [31:0]  div_remainder;
    instruction_t cur;
    result_t      exec_res;
    result_t      q_mag;
    result_t      r_mag;
    result_t      div_res;

    assign load_ready       = (state == S_IDLE);
    assign accept           = load_en && load_ready;
    assign is_div_op        = (opcode == DIV) || (opcode == MOD);
    assign div_start        = accept && is_div_op && (operand_b != '0);
    assign mag_a            = operand_a[31] ? 32'(-operand_a) : operand_a;
    assign mag_b            = operand_b[31] ? 32'(-operand_b) : operand_b;
    assign cur              = mem[cur_ptr];
    assign instruction_word = mem[read_pointer];
    assign entry_valid      = valid[read_pointer];

    instr_divider #(
        .WIDTH  (32),
        .CYCLES (DIV_CYCLES)
    ) u_divider (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .done      (div_done),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    // DIV/MOD only reach EXEC with a zero divisor, so they fall into the zero default
    always_comb begin
        exec_res = '0;
        case (cur.opc)
            PASSA:   exec_res = sext(cur.op_a);
            PASSB:   exec_res = sext(cur.op_b);
            ADD:     exec_res = sext(cur.op_a) + sext(cur.op_b);
            SUB:     exec_res = sext(cur.op_a) - sext(cur.op_b);
            MULT:    exec_res = sext(cur.op_a) * sext(cur.op_b);
            default: exec_res = '0;
        endcase
    end

    // Operands of the in-flight entry are still in storage, so signs are taken from there
    assign q_mag   = {32'd0, div_quotient};
    assign r_mag   = {32'd0, div_remainder};
    assign div_res = (cur.opc == MOD)
                   ? (cur.op_a[31] ? -r_mag : r_mag)
                   : ((cur.op_a[31] ^ cur.op_b[31]) ? -q_mag : q_mag);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cur_ptr     <= '0;
            div_cnt     <= '0;
            div_by_zero <= 1'b0;
            valid       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            div_by_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mem[write_pointer]   <= '{opc: opcode, op_a: operand_a,
                                                  op_b: operand_b, rezultat: '0};
                        valid[write_pointer] <= 1'b0;
                        cur_ptr              <= write_pointer;
                        div_cnt              <= '0;
                        if (div_start) begin
                            state <= S_DIVIDE;
                        end else begin
                            state       <= S_EXEC;
                            div_by_zero <= is_div_op;
                        end
                    end
                end
                S_EXEC: begin
                    mem[cur_ptr].rezultat <= exec_res;
                    valid[cur_ptr]        <= 1'b1;
                    state                 <= S_IDLE;
                end
                S_DIVIDE: begin
                    if (div_cnt == CW'(DIV_CYCLES - 1)) begin
                        state <= S_WRITEBACK;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    if (div_done) begin
                        mem[cur_ptr].rezultat <= div_res;
                        valid[cur_ptr]        <= 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_register_exec.sv
// Randomized and directed bench for instr_register_exec against an arithmetic reference model.
module tb_instr_register_exec;
    import instr_register_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         load_en = 1'b0;
    logic         load_ready;
    address_t     write_pointer = '0;
    opcode_t      opcode = ZERO;
    operand_t     operand_a = '0;
    operand_t     operand_b = '0;
    address_t     read_pointer = '0;
    instruction_t instruction_word;
    logic         entry_valid;
    logic         div_by_zero;

    int errors = 0;
    int checks = 0;

    // reference contents of every entry
    logic [3:0] m_opc [32];
    int         m_a   [32];
    int         m_b   [32];
    longint     m_rez [32];
    bit         m_vld [32];

    // observations from the most recent run_op
    int           obs_low;
    int           obs_dbz;
    instruction_t obs_inflight;
    logic         obs_inflight_vld;
    instruction_t obs_final;
    logic         obs_final_vld;
    bit           obs_timeout;

    instr_register_exec dut (
        .clk              (clk),
        .reset            (reset),
        .load_en          (load_en),
        .load_ready       (load_ready),
        .write_pointer    (write_pointer),
        .opcode           (opcode),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .entry_valid      (entry_valid),
        .div_by_zero      (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic longint model_result(input logic [3:0] op, input int a, input int b);
        longint la = a;
        longint lb = b;
        case (op)
            4'd0: return 0;
            4'd1: return la;
            4'd2: return lb;
            4'd3: return la + lb;
            4'd4: return la - lb;
            4'd5: return la * lb;
            4'd6: return (b == 0) ? 0 : la / lb;
            4'd7: return (b == 0) ? 0 : la % lb;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_low(input logic [3:0] op, input int b);
        return ((op == 4'd6 || op == 4'd7) && b != 0) ? 33 : 1;
    endfunction

    function automatic int exp_dbz(input logic [3:0] op, input int b);
        return ((op == 4'd6 || op == 4'd7) && b == 0) ? 1 : 0;
    endfunction

    function automatic int rand_operand();
        case ($urandom_range(0, 4))
            0: return int'($urandom_range(0, 40)) - 20;
            1: return 32'h8000_0000;
            2: return 32'h7FFF_FFFF;
            3: return 0;
            default: return int'($urandom);
        endcase
    endfunction

    function automatic void model_clear();
        for (int p = 0; p < 32; p++) begin
            m_opc[p] = '0; m_a[p] = 0; m_b[p] = 0; m_rez[p] = 0; m_vld[p] = 0;
        end
    endfunction

    // Issue one write (called at a negedge with load_ready high) and observe it to completion.
    task automatic run_op(input logic [4:0] ptr, input logic [3:0] op, input int a, input int b);
        write_pointer = ptr; opcode = opcode_t'(op); operand_a = a; operand_b = b;
        read_pointer = ptr; load_en = 1'b1;
        @(posedge clk);
        #1 load_en = 1'b0;
        obs_low = 0; obs_dbz = 0; obs_timeout = 1'b0;
        @(negedge clk);
        obs_inflight = instruction_word;
        obs_inflight_vld = entry_valid;
        for (int i = 0; i < 100; i++) begin
            if (div_by_zero) obs_dbz++;
            if (load_ready) break;
            obs_low++;
            @(negedge clk);
        end
        if (!load_ready) obs_timeout = 1'b1;
        obs_final = instruction_word;
        obs_final_vld = entry_valid;
        m_opc[ptr] = op; m_a[ptr] = a; m_b[ptr] = b;
        m_rez[ptr] = model_result(op, a, b); m_vld[ptr] = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready: got %b want 1", load_ready); end
        checks++; if (entry_valid !== 1'b0) begin errors++; $display("FAIL reset_entry_valid: got %b want 0", entry_valid); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_div_by_zero: got %b want 0", div_by_zero); end
        checks++; if (instruction_word !== '0) begin errors++; $display("FAIL reset_word: got %h want 0", instruction_word); end
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", load_ready); end
    endtask

    task automatic test_add();
        run_op(5'd3, 4'd3, -15, 7);
        checks++; if (obs_timeout) begin errors++; $display("FAIL add_timeout: load_ready never returned"); end
        checks++; if (obs_inflight.rezultat !== 64'sd0 || obs_inflight_vld !== 1'b0 || obs_inflight.opc !== ADD)
            begin errors++; $display("FAIL add_inflight: got opc=%0d rez=%0d vld=%b want opc=3 rez=0 vld=0",
                obs_inflight.opc, obs_inflight.rezultat, obs_inflight_vld); end
        checks++; if (obs_final.rezultat !== -64'sd8 || obs_final_vld !== 1'b1)
            begin errors++; $display("FAIL add_result: got %0d vld=%b want -8 vld=1", obs_final.rezultat, obs_final_vld); end
        checks++; if (obs_low !== 1) begin errors++; $display("FAIL add_ready_low: got %0d want 1", obs_low); end
    endtask

    task automatic test_mult();
        run_op(5'd0, 4'd5, 32'h7FFF_FFFF, 2);
        checks++; if (obs_final.rezultat !== 64'h0000_0000_FFFF_FFFE || obs_final_vld !== 1'b1)
            begin errors++; $display("FAIL mult_result: got %h vld=%b want 00000000fffffffe vld=1", obs_final.rezultat, obs_final_vld); end
    endtask

    task automatic test_div_mod();
        run_op(5'd5, 4'd6, -15, 4);
        checks++; if (obs_final.rezultat !== -64'sd3 || obs_final_vld !== 1'b1)
            begin errors++; $display("FAIL div_result: got %0d vld=%b want -3 vld=1", obs_final.rezultat, obs_final_vld); end
        checks++; if (obs_low !== 33) begin errors++; $display("FAIL div_ready_low: got %0d want 33", obs_low); end
        checks++; if (obs_inflight_vld !== 1'b0 || obs_inflight.op_b !== 32'sd4)
            begin errors++; $display("FAIL div_inflight: got vld=%b op_b=%0d want vld=0 op_b=4", obs_inflight_vld, obs_inflight.op_b); end
        run_op(5'd6, 4'd7, -15, 4);
        checks++; if (obs_final.rezultat !== -64'sd3 || obs_final_vld !== 1'b1)
            begin errors++; $display("FAIL mod_result: got %0d vld=%b want -3 vld=1", obs_final.rezultat, obs_final_vld); end
    endtask

    task automatic test_div_zero();
        run_op(5'd7, 4'd6, 9, 0);
        checks++; if (obs_final.rezultat !== 64'sd0 || obs_final_vld !== 1'b1)
            begin errors++; $display("FAIL divzero_result: got %0d vld=%b want 0 vld=1", obs_final.rezultat, obs_final_vld); end
        checks++; if (obs_dbz !== 1) begin errors++; $display("FAIL divzero_pulse: got %0d cycles want 1", obs_dbz); end
        checks++; if (obs_low !== 1) begin errors++; $display("FAIL divzero_ready_low: got %0d want 1", obs_low); end
    endtask

    task automatic test_busy_ignore();
        bit returned = 1'b0;
        write_pointer = 5'd9; opcode = DIV; operand_a = 100; operand_b = 7; load_en = 1'b1;
        @(posedge clk);
        #1 write_pointer = 5'd8; opcode = ADD; operand_a = int'($urandom); operand_b = 5;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (load_ready) begin load_en = 1'b0; returned = 1'b1; break; end
        end
        load_en = 1'b0;
        m_opc[9] = 4'd6; m_a[9] = 100; m_b[9] = 7; m_rez[9] = model_result(4'd6, 100, 7); m_vld[9] = 1'b1;
        checks++; if (!returned) begin errors++; $display("FAIL busy_timeout: load_ready never returned"); end
        read_pointer = 5'd8; #1;
        checks++; if (instruction_word !== '0 || entry_valid !== 1'b0)
            begin errors++; $display("FAIL busy_entry8: got %h vld=%b want 0 vld=0", instruction_word, entry_valid); end
        read_pointer = 5'd9; #1;
        checks++; if (instruction_word.rezultat !== m_rez[9] || entry_valid !== 1'b1)
            begin errors++; $display("FAIL busy_entry9: got %0d vld=%b want %0d vld=1", instruction_word.rezultat, entry_valid, m_rez[9]); end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [4:0] ptr = 5'($urandom_range(0, 31));
            logic [3:0] op = 4'($urandom_range(0, 9));
            int a = rand_operand();
            int b = rand_operand();
            run_op(ptr, op, a, b);
            checks++; if (obs_timeout || obs_low !== exp_low(op, b))
                begin errors++; $display("FAIL rand_ready_low[%0d]: op=%0d got %0d timeout=%b want %0d", n, op, obs_low, obs_timeout, exp_low(op, b)); end
            checks++; if (obs_dbz !== exp_dbz(op, b))
                begin errors++; $display("FAIL rand_dbz[%0d]: op=%0d got %0d want %0d", n, op, obs_dbz, exp_dbz(op, b)); end
            checks++; if (obs_inflight.opc !== op || obs_inflight.op_a !== a || obs_inflight.op_b !== b
                          || obs_inflight.rezultat !== 64'sd0 || obs_inflight_vld !== 1'b0)
                begin errors++; $display("FAIL rand_inflight[%0d]: got %h vld=%b want opc=%0d a=%0d b=%0d rez=0 vld=0",
                    n, obs_inflight, obs_inflight_vld, op, a, b); end
            checks++; if (obs_final.rezultat !== m_rez[ptr] || obs_final_vld !== 1'b1)
                begin errors++; $display("FAIL rand_result[%0d]: op=%0d a=%0d b=%0d got %0d vld=%b want %0d vld=1",
                    n, op, a, b, obs_final.rezultat, obs_final_vld, m_rez[ptr]); end
        end
        for (int p = 0; p < 32; p++) begin
            read_pointer = 5'(p); #1;
            checks++; if (instruction_word.opc !== m_opc[p] || instruction_word.op_a !== m_a[p]
                          || instruction_word.op_b !== m_b[p] || instruction_word.rezultat !== m_rez[p]
                          || entry_valid !== m_vld[p])
                begin errors++; $display("FAIL sweep[%0d]: got %h vld=%b want opc=%0d a=%0d b=%0d rez=%0d vld=%b",
                    p, instruction_word, entry_valid, m_opc[p], m_a[p], m_b[p], m_rez[p], m_vld[p]); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_divide();
        int nonzero = 0;
        write_pointer = 5'd10; opcode = DIV; operand_a = 1000; operand_b = 3; read_pointer = 5'd10; load_en = 1'b1;
        @(posedge clk);
        #1 load_en = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checks++; if (instruction_word !== '0 || entry_valid !== 1'b0 || load_ready !== 1'b1)
            begin errors++; $display("FAIL midreset_async: got %h vld=%b rdy=%b want 0 0 1", instruction_word, entry_valid, load_ready); end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        checks++; if (load_ready !== 1'b1 || entry_valid !== 1'b0 || instruction_word !== '0)
            begin errors++; $display("FAIL midreset_first_edge: rdy=%b vld=%b word=%h want 1 0 0", load_ready, entry_valid, instruction_word); end
        repeat (40) @(negedge clk);
        for (int p = 0; p < 32; p++) begin
            read_pointer = 5'(p); #1;
            if (instruction_word !== '0 || entry_valid !== 1'b0) nonzero++;
        end
        checks++; if (nonzero !== 0) begin errors++; $display("FAIL midreset_no_writeback: %0d nonzero entries want 0", nonzero); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mult();
        test_div_mod();
        test_div_zero();
        test_busy_ignore();
        test_random();
        test_reset_mid_divide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
